// File: rtl/branch_predictor.sv
// Branch target buffer with selectable predictor (static, 1-bit, 2-bit saturating).
// Fetch reads the table combinationally; decode resolves the branch and trains the table.
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int MODE    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush_d,
  input  logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  input  logic        is_branch_d,
  input  logic        taken_d,
  input  logic [31:0] pc_branch_d,
  output logic [31:0] predict_pc,
  output logic        last_taken,
  output logic        miss,
  output logic [31:0] recover_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] miss_cnt
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TAG = 30 - IDX;

  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  // MODE 1 keeps its single outcome bit in the counter MSB so prediction reads one bit.
  localparam logic [1:0] CTR_RST   = (MODE == 32'sd2) ? 2'b01 : 2'b00;
  localparam logic [1:0] CTR_ALLOC = 2'b10;

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (MODE == 32'sd1) begin
      nxt = taken ? 2'b10 : 2'b00;
    end else if (taken) begin
      nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return nxt;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic            valid_q  [ENTRIES];
  logic            valid_d  [ENTRIES];
  logic [TAG-1:0]  tag_q    [ENTRIES];
  logic [TAG-1:0]  tag_d    [ENTRIES];
  logic [31:0]     target_q [ENTRIES];
  logic [31:0]     target_d [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];
  logic [1:0]      ctr_d    [ENTRIES];

  logic            last_taken_q, last_taken_d;
  logic [31:0]     pc_d_q, pc_d_d;
  logic [31:0]     branch_cnt_q, branch_cnt_d;
  logic [31:0]     miss_cnt_q, miss_cnt_d;

  logic [IDX-1:0]  idx_f_s, idx_d_s;
  logic [TAG-1:0]  tag_f_s, tag_d_s;
  logic            is_br_f_s, hit_f_s, pred_f_s, hit_d_s, upd_s, miss_s;
  logic            unused_s;

  assign unused_s = ^{instr_f[25:0], pc_f[1:0], pc_d_q[1:0]};

  // Fetch-side lookup and next-PC selection
  always_comb begin
    idx_f_s   = pc_f[IDX+1:2];
    tag_f_s   = pc_f[31:IDX+2];
    is_br_f_s = (instr_f[31:26] == OP_BEQ) || (instr_f[31:26] == OP_BNE);
    hit_f_s   = valid_q[idx_f_s] && (tag_q[idx_f_s] == tag_f_s);
    if ((MODE != 32'sd0) && is_br_f_s && hit_f_s) begin
      pred_f_s = ctr_q[idx_f_s][1];
    end else begin
      pred_f_s = 1'b0;
    end
    predict_pc = pred_f_s ? target_q[idx_f_s] : pc_f + 32'd4;
  end

  // Decode-side resolution, F->D capture and statistics
  always_comb begin
    upd_s        = is_branch_d & en;
    miss_s       = is_branch_d & (taken_d != last_taken_q);
    recover_pc   = taken_d ? pc_branch_d : pc_d_q + 32'd4;
    last_taken_d = last_taken_q;
    pc_d_d       = pc_d_q;
    if (flush_d) begin
      last_taken_d = 1'b0;
    end else if (en) begin
      last_taken_d = pred_f_s;
    end else begin
      last_taken_d = last_taken_q;
    end
    if (en) begin
      pc_d_d = pc_f;
    end else begin
      pc_d_d = pc_d_q;
    end
    branch_cnt_d = upd_s ? sat_inc(branch_cnt_q) : branch_cnt_q;
    miss_cnt_d   = (upd_s && miss_s) ? sat_inc(miss_cnt_q) : miss_cnt_q;
  end

  // Table training; writes land at the edge, so same-cycle fetch sees the old entry
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    idx_d_s  = pc_d_q[IDX+1:2];
    tag_d_s  = pc_d_q[31:IDX+2];
    hit_d_s  = valid_q[idx_d_s] && (tag_q[idx_d_s] == tag_d_s);
    if ((MODE != 32'sd0) && upd_s) begin
      if (hit_d_s) begin
        ctr_d[idx_d_s] = ctr_update(ctr_q[idx_d_s], taken_d);
        if (taken_d) begin
          target_d[idx_d_s] = pc_branch_d;
        end else begin
          target_d[idx_d_s] = target_q[idx_d_s];
        end
      end else if (taken_d) begin
        valid_d[idx_d_s]  = 1'b1;
        tag_d[idx_d_s]    = tag_d_s;
        target_d[idx_d_s] = pc_branch_d;
        ctr_d[idx_d_s]    = CTR_ALLOC;
      end else begin
        valid_d[idx_d_s]  = valid_q[idx_d_s];
      end
    end else begin
      valid_d[idx_d_s] = valid_q[idx_d_s];
    end
  end

  // State registers; asynchronous reset discards any in-flight entry write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= {TAG{1'b0}};
        target_q[i] <= 32'd0;
        ctr_q[i]    <= CTR_RST;
      end
      last_taken_q <= 1'b0;
      pc_d_q       <= 32'd0;
      branch_cnt_q <= 32'd0;
      miss_cnt_q   <= 32'd0;
    end else begin
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      target_q     <= target_d;
      ctr_q        <= ctr_d;
      last_taken_q <= last_taken_d;
      pc_d_q       <= pc_d_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign last_taken = last_taken_q;
  assign miss       = miss_s;
  assign branch_cnt = branch_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: MODE 0/1/2 instances driven in lockstep against a
// table-of-records reference model, with directed scenarios followed by random traffic.
module tb_branch_predictor;

  localparam logic [31:0] BEQ = 32'h1000_0000;
  localparam logic [31:0] BNE = 32'h1400_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        flush_d = 1'b0;
  logic [31:0] pc_f = 32'd0;
  logic [31:0] instr_f = 32'd0;
  logic        is_branch_d = 1'b0;
  logic        taken_d = 1'b0;
  logic [31:0] pc_branch_d = 32'd0;

  logic [31:0] o_ppc [3];
  logic        o_last [3];
  logic        o_miss [3];
  logic [31:0] o_rec [3];
  logic [31:0] o_bc [3];
  logic [31:0] o_mc [3];

  int n_total = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(64), .MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .en(en), .flush_d(flush_d), .pc_f(pc_f), .instr_f(instr_f),
    .is_branch_d(is_branch_d), .taken_d(taken_d), .pc_branch_d(pc_branch_d),
    .predict_pc(o_ppc[0]), .last_taken(o_last[0]), .miss(o_miss[0]),
    .recover_pc(o_rec[0]), .branch_cnt(o_bc[0]), .miss_cnt(o_mc[0]));

  branch_predictor #(.ENTRIES(64), .MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .en(en), .flush_d(flush_d), .pc_f(pc_f), .instr_f(instr_f),
    .is_branch_d(is_branch_d), .taken_d(taken_d), .pc_branch_d(pc_branch_d),
    .predict_pc(o_ppc[1]), .last_taken(o_last[1]), .miss(o_miss[1]),
    .recover_pc(o_rec[1]), .branch_cnt(o_bc[1]), .miss_cnt(o_mc[1]));

  branch_predictor #(.ENTRIES(64), .MODE(2)) u_m2 (
    .clk(clk), .rst(rst), .en(en), .flush_d(flush_d), .pc_f(pc_f), .instr_f(instr_f),
    .is_branch_d(is_branch_d), .taken_d(taken_d), .pc_branch_d(pc_branch_d),
    .predict_pc(o_ppc[2]), .last_taken(o_last[2]), .miss(o_miss[2]),
    .recover_pc(o_rec[2]), .branch_cnt(o_bc[2]), .miss_cnt(o_mc[2]));

  // Reference model: one record per slot, owner PC kept whole, strength as an integer.
  bit          mv   [3][64];
  bit   [31:0] mown [3][64];
  bit   [31:0] mtgt [3][64];
  int          mctr [3][64];
  bit          mlast [3];
  bit   [31:0] mpcd [3];
  bit   [31:0] mbc  [3];
  bit   [31:0] mmc  [3];

  logic [31:0] snap_ppc [3];
  logic        snap_last [3];
  logic        snap_miss [3];
  logic [31:0] snap_rec [3];
  logic [31:0] snap_bc [3];
  logic [31:0] snap_mc [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int slot(input bit [31:0] pc);
    return int'((pc / 32'd4) % 32'd64);
  endfunction

  function automatic bit owns(input int m, input bit [31:0] pc);
    int i = slot(pc);
    return mv[m][i] && ((mown[m][i] / 32'd256) == (pc / 32'd256));
  endfunction

  function automatic bit m_pred(input int m, input bit [31:0] pc, input bit [31:0] ins);
    bit [31:0] op = ins >> 26;
    int i = slot(pc);
    if (m == 0 || !(op == 32'd4 || op == 32'd5) || !owns(m, pc)) return 1'b0;
    if (m == 1) return mctr[m][i] == 1;
    return mctr[m][i] >= 2;
  endfunction

  task automatic m_reset(input int m);
    for (int i = 0; i < 64; i++) begin
      mv[m][i] = 1'b0;
      mctr[m][i] = (m == 2) ? 1 : 0;
    end
    mlast[m] = 1'b0;
    mpcd[m] = 32'd0;
    mbc[m] = 32'd0;
    mmc[m] = 32'd0;
  endtask

  task automatic m_update(input int m);
    bit p = m_pred(m, pc_f, instr_f);
    bit ms = is_branch_d && (taken_d != mlast[m]);
    int i = slot(mpcd[m]);
    if (is_branch_d && en) begin
      if (mbc[m] != 32'hFFFF_FFFF) mbc[m] = mbc[m] + 32'd1;
      if (ms && mmc[m] != 32'hFFFF_FFFF) mmc[m] = mmc[m] + 32'd1;
      if (m != 0) begin
        if (owns(m, mpcd[m])) begin
          if (m == 1) mctr[m][i] = taken_d ? 1 : 0;
          else mctr[m][i] = taken_d ? ((mctr[m][i] < 3) ? mctr[m][i] + 1 : 3)
                                    : ((mctr[m][i] > 0) ? mctr[m][i] - 1 : 0);
          if (taken_d) mtgt[m][i] = pc_branch_d;
        end else if (taken_d) begin
          mv[m][i] = 1'b1;
          mown[m][i] = mpcd[m];
          mtgt[m][i] = pc_branch_d;
          mctr[m][i] = (m == 2) ? 2 : 1;
        end
      end
    end
    if (flush_d) mlast[m] = 1'b0;
    else if (en) mlast[m] = p;
    if (en) mpcd[m] = pc_f;
  endtask

  task automatic check_outputs(input int m);
    bit p = m_pred(m, pc_f, instr_f);
    bit [31:0] eppc = p ? mtgt[m][slot(pc_f)] : pc_f + 32'd4;
    chk($sformatf("m%0d_predict_pc", m), o_ppc[m], eppc);
    chk($sformatf("m%0d_last_taken", m), {31'd0, o_last[m]}, {31'd0, mlast[m]});
    chk($sformatf("m%0d_miss", m), {31'd0, o_miss[m]},
        {31'd0, is_branch_d && (taken_d != mlast[m])});
    chk($sformatf("m%0d_recover_pc", m), o_rec[m], taken_d ? pc_branch_d : mpcd[m] + 32'd4);
    chk($sformatf("m%0d_branch_cnt", m), o_bc[m], mbc[m]);
    chk($sformatf("m%0d_miss_cnt", m), o_mc[m], mmc[m]);
    snap_ppc[m] = o_ppc[m];
    snap_last[m] = o_last[m];
    snap_miss[m] = o_miss[m];
    snap_rec[m] = o_rec[m];
    snap_bc[m] = o_bc[m];
    snap_mc[m] = o_mc[m];
  endtask

  task automatic step(input logic [31:0] pc, input logic [31:0] ins, input logic br,
                      input logic tk, input logic [31:0] pcb, input logic e,
                      input logic fl, input logic r);
    @(negedge clk);
    pc_f = pc;
    instr_f = ins;
    is_branch_d = br;
    taken_d = tk;
    pc_branch_d = pcb;
    en = e;
    flush_d = fl;
    rst = r;
    if (!r) for (int m = 0; m < 3; m++) m_reset(m);
    #1;
    for (int m = 0; m < 3; m++) check_outputs(m);
    @(posedge clk);
    if (rst) for (int m = 0; m < 3; m++) m_update(m);
  endtask

  initial begin
    logic [31:0] pc, ins, pcb, bc0;
    int sel;
    for (int m = 0; m < 3; m++) m_reset(m);

    // cold branch, allocation, weakening, aliasing
    step(32'h10, NOP, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("reset_bc", snap_bc[2], 32'd0);
    step(32'h10, BEQ, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("cold_ppc", snap_ppc[2], 32'h14);
    step(32'h14, NOP, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
    chk("cold_miss", {31'd0, snap_miss[2]}, 32'd1);
    chk("cold_recover", snap_rec[2], 32'h40);
    step(32'h10, BEQ, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("warm_ppc", snap_ppc[2], 32'h40);
    step(32'h14, NOP, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b1);
    chk("nt1_miss", {31'd0, snap_miss[2]}, 32'd1);
    chk("nt1_recover", snap_rec[2], 32'h14);
    step(32'h10, BEQ, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("weak_ppc", snap_ppc[2], 32'h14);
    step(32'h14, NOP, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b1);
    chk("nt2_miss", {31'd0, snap_miss[2]}, 32'd0);
    step(32'h110, BEQ, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("nt_miss_cnt", snap_mc[2], 32'd2);
    chk("nt_branch_cnt", snap_bc[2], 32'd3);
    chk("alias_cold_ppc", snap_ppc[2], 32'h114);
    step(32'h14, NOP, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 1'b1);
    step(32'h110, BEQ, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("alias_new_ppc", snap_ppc[2], 32'h200);
    step(32'h10, BEQ, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("alias_old_ppc", snap_ppc[2], 32'h14);

    // stall with a branch waiting in decode
    step(32'h110, BNE, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    bc0 = snap_bc[2];
    for (int k = 0; k < 3; k++) begin
      step(32'h14, NOP, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b1);
      chk("stall_last", {31'd0, snap_last[2]}, 32'd1);
      chk("stall_bc", snap_bc[2], bc0);
    end
    step(32'h14, NOP, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 1'b1);
    step(32'h14, NOP, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("release_bc", snap_bc[2], bc0 + 32'd1);

    // reset after warm-up
    step(32'h110, BEQ, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(32'h110, BEQ, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("post_rst_ppc", snap_ppc[2], 32'h114);
    chk("post_rst_bc", snap_bc[2], 32'd0);
    chk("post_rst_mc", snap_mc[2], 32'd0);

    // static predictor never learns
    for (int k = 0; k < 10; k++) begin
      step(32'h10, BEQ, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
      chk("static_ppc", snap_ppc[0], 32'h14);
    end
    step(32'h10, BEQ, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("static_mc", snap_mc[0], 32'd10);
    chk("static_ppc_final", snap_ppc[0], 32'h14);

    // random traffic over a small PC pool to force hits and aliasing
    for (int k = 0; k < 3000; k++) begin
      pc = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 2)) << 8);
      sel = $urandom_range(0, 3);
      ins = {26'd0, 6'($urandom)};
      case (sel)
        0: ins = BEQ | ins;
        1: ins = BNE | ins;
        2: ins = NOP | ins;
        default: ins = $urandom;
      endcase
      pcb = {$urandom_range(0, 255), 2'b00};
      step(pc, ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pcb,
           $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) != 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
